xor_share_arbiter: RTL and testbench
====================================

# xor_share_arbiter

Round-robin arbiter and sequencer that shares one `four_input_xor_gate_a` parity unit among four requesters. Each requester presents a 4-bit operand and raises `req`. The block grants one requester, drives its operand through the gate, registers the parity result and returns it with a one-cycle `done` pulse. It then completes a 4-phase handshake before serving the next requester. It sits between the lab's stimulus/requester logic and the shared XOR datapath.

## Interface
- `NUM_REQ`, 4: number of requesters; fixed at 4 in this revision.
- `CNT_W`, 8: width of the completed-transaction counter.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input 4: per-requester request, held high until the requester sees `done`.
- `op` input 16: packed operands; requester i uses `op[4i+3:4i]`.
- `gnt` output 4: one-hot grant, zero when idle.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse; `result` is valid.
- `result` output 1: registered parity of the granted operand; holds until the next `done`.
- `gnt_id` output 2: index of the current or last granted requester.
- `txn_cnt` output CNT_W: completed transactions; wraps from 255 to 0.

## Operation
- States:
  - IDLE: if `req` is nonzero, pick the winner by round-robin, set `gnt`, latch the operand into gate-input registers, go to EVAL.
  - EVAL: `result` <= gate output `e`, `done` <= 1, `txn_cnt` += 1, go to RESP.
  - RESP: `done` <= 0, go to WAIT.
  - WAIT: when `req[gnt_id]`==0, clear `gnt`, advance the pointer to `gnt_id`+1 (mod 4), go to IDLE.
- Round-robin: search starts at the priority pointer and scans upward mod 4. The first set `req` bit wins. Pointer resets to 0.
- Gate-input bit map: a=`op[4i+3]`, b=`op[4i+2]`, c=`op[4i+1]`, d=`op[4i]`. `result` = a^b^c^d.
- Operand is sampled only at the granting edge. Changes to `op` afterwards do not affect the in-flight result.
- Requester drops `req` during EVAL or RESP (abort): the transaction still completes, `done` still pulses and `txn_cnt` still increments. WAIT then exits on its first cycle.
- `req` bits of non-granted requesters may change freely and are only examined in IDLE.
- Reset, asynchronous and valid mid-transaction:
  - State returns to IDLE.
  - `gnt`=0, `busy`=0, `done`=0, `result`=0, `gnt_id`=0, `txn_cnt`=0.
  - Pointer=0 and gate-input registers=0.
  - No `done` is produced for the aborted transaction.

## Timing
- All outputs are registered. Nothing is combinational from `req` or `op` to any output.
- IDLE at edge k with `req` nonzero:
  - `gnt` and `busy` are high after edge k.
  - `done` and `result` are valid after edge k+1, for one cycle.
  - `done` is low after edge k+2.
- WAIT lasts at least one cycle. With `req` dropped immediately after `done`, `gnt` falls after edge k+3 and the next grant is no earlier than edge k+4. Minimum period is 4 cycles per transaction.
- `gnt` is stable from the grant edge until the WAIT exit edge.
- `txn_cnt` updates on the same edge that raises `done`.

## Structure
- Shared package `xor_arb_pkg`:
  - state encoding constants IDLE=0, EVAL=1, RESP=2, WAIT=3;
  - `NUM_REQ`;
  - operand width 4.
- One sub-module: instantiate the existing `four_input_xor_gate_a` (ports a, b, c, d, e) as the shared datapath, driven from the gate-input registers.
- The round-robin winner selection is a local function in the top module. No separate module.

## Test plan
- Reset then a single request: `req`=4'b0001, `op[3:0]`=4'b1011 → `gnt`=0001 one cycle later, then `done`=1 with `result`=1 and `txn_cnt`=1. Drop `req` → `gnt`=0 and `busy`=0.
- Exhaustive parity: requester 2 issues all 16 operand values in sequence → `result` matches the XOR of the 4 bits every time and `txn_cnt`=16.
- Fairness: `req`=4'b1111 held with immediate re-requests → grant order 0,1,2,3,0. Each requester gets one `done` per four transactions.
- Abort: `req[1]` drops one cycle after `gnt`=0010 → `done` still pulses, WAIT exits in one cycle, then requester 2 is granted next if pending.
- Operand change after grant: `op[7:4]` changes from 4'b0001 to 4'b0011 in EVAL → `result`=1 (the latched value).
- Reset mid-operation: assert `reset_n`=0 during EVAL → all outputs 0 immediately. After release, no `done` appears and `req`=0001 is granted first (pointer=0). Also run 256 transactions → `txn_cnt` wraps to 0.

Source files
------------

// File: rtl/xor_arb_pkg.sv
// Shared constants and state encoding for the XOR-sharing arbiter.
// The requester count and operand width are fixed in this revision.
package xor_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int OP_W    = 4;
    localparam int ID_W    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2,
        WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/four_input_xor_gate_a.sv
// Shared parity datapath: a purely combinational four-input XOR.
module four_input_xor_gate_a (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic e
);

    assign e = a ^ b ^ c ^ d;

endmodule

// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter that time-shares one four_input_xor_gate_a among
// four requesters with a done pulse and a 4-phase release handshake.
module xor_share_arbiter
    import xor_arb_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*OP_W-1:0] op,
    output logic [NUM_REQ-1:0]      gnt,
    output logic                    busy,
    output logic                    done,
    output logic                    result,
    output logic [ID_W-1:0]         gnt_id,
    output logic [CNT_W-1:0]        txn_cnt,
    output logic [1:0]              fsm_state
);

    // Handshake: a requester raises req[i] and holds it until it sees done;
    // the grant is released only once the granted requester drops req.

    state_t              state, state_nxt;
    logic [ID_W-1:0]     ptr, ptr_nxt;
    logic [OP_W-1:0]     opnd, opnd_nxt;
    logic [NUM_REQ-1:0]  gnt_nxt;
    logic [ID_W-1:0]     id_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic                result_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [ID_W-1:0]     winner;
    logic                gate_e;

    // Lowest offset from the pointer wins; the 2-bit index wraps mod 4.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [ID_W-1:0]    p);
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] pick;
        pick = p;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            idx = p + ID_W'(j);
            if (r[idx]) pick = idx;
        end
        return pick;
    endfunction

    four_input_xor_gate_a u_gate (
        .a (opnd[3]),
        .b (opnd[2]),
        .c (opnd[1]),
        .d (opnd[0]),
        .e (gate_e)
    );

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        opnd_nxt   = opnd;
        gnt_nxt    = gnt;
        id_nxt     = gnt_id;
        done_nxt   = done;
        result_nxt = result;
        cnt_nxt    = txn_cnt;
        winner     = rr_pick(req, ptr);
        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_nxt   = NUM_REQ'(1) << winner;
                    id_nxt    = winner;
                    opnd_nxt  = op[winner*OP_W +: OP_W];
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                result_nxt = gate_e;
                done_nxt   = 1'b1;
                cnt_nxt    = txn_cnt + 1'b1;
                state_nxt  = RESP;
            end
            RESP: begin
                done_nxt  = 1'b0;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (!req[gnt_id]) begin
                    gnt_nxt   = '0;
                    ptr_nxt   = gnt_id + 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr     <= '0;
            opnd    <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= 1'b0;
            txn_cnt <= '0;
        end else begin
            ptr     <= ptr_nxt;
            opnd    <= opnd_nxt;
            gnt     <= gnt_nxt;
            gnt_id  <= id_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            result  <= result_nxt;
            txn_cnt <= cnt_nxt;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Bench for xor_share_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_xor_share_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [15:0] op;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic        result;
    logic [1:0]  gnt_id;
    logic [7:0]  txn_cnt;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    xor_share_arbiter #(.CNT_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .op        (op),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .gnt_id    (gnt_id),
        .txn_cnt   (txn_cnt),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Tracks a transaction by the number of edges since its grant.
    bit         m_active = 0;
    int         m_t      = 0;
    int         m_w      = 0;
    int         m_ptr    = 0;
    logic [3:0] m_opnd   = '0;
    logic       m_done   = 1'b0;
    logic       m_result = 1'b0;
    logic [7:0] m_cnt    = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 0; m_t = 0; m_w = 0; m_ptr = 0;
            m_opnd = '0; m_done = 1'b0; m_result = 1'b0; m_cnt = '0;
        end else if (!m_active) begin
            if (req != 4'b0000) begin
                bit found;
                found = 0;
                for (int j = 0; j < 4; j++) begin
                    if (!found && req[(m_ptr + j) % 4]) begin
                        m_w = (m_ptr + j) % 4;
                        found = 1;
                    end
                end
                m_opnd   = op[m_w*4 +: 4];
                m_active = 1;
                m_t      = 0;
            end
        end else begin
            if (m_t == 0) begin
                m_done   = 1'b1;
                m_result = ($countones(m_opnd) % 2) == 1;
                m_cnt    = m_cnt + 8'd1;
            end else if (m_t == 1) begin
                m_done = 1'b0;
            end else if (!req[m_w]) begin
                m_active = 0;
                m_ptr    = (m_w + 1) % 4;
            end
            m_t++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [3:0] eg;
        int         es;
        eg = m_active ? (4'b0001 << m_w) : 4'b0000;
        es = !m_active ? 0 : (m_t == 0) ? 1 : (m_t == 1) ? 2 : 3;
        check("gnt",     32'(gnt),       32'(eg));
        check("busy",    32'(busy),      32'(m_active));
        check("done",    32'(done),      32'(m_done));
        check("result",  32'(result),    32'(m_result));
        check("gnt_id",  32'(gnt_id),    32'(m_w));
        check("txn_cnt", 32'(txn_cnt),   32'(m_cnt));
        check("state",   32'(fsm_state), 32'(es));
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req     = '0;
        op      = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (done) ok = 1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_done: got no done expected done within 20 cycles");
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (!busy) ok = 1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_idle: got busy expected idle within 20 cycles");
        end
    endtask

    // ---------------- scenarios ----------------
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];

    initial begin
        int         w;
        int         par;
        logic [3:0] v;
        logic [3:0] r;
        logic [1:0] e_id;

        reset_n = 1'b0;
        req     = '0;
        op      = '0;

        // Reset then a single request
        apply_reset();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_cnt", 32'(txn_cnt), 32'h0);
        req = 4'b0001;
        op  = 16'h000B;
        tick();
        check("single_gnt", 32'(gnt), 32'h1);
        check("single_busy", 32'(busy), 32'h1);
        tick();
        check("single_done", 32'(done), 32'h1);
        check("single_result", 32'(result), 32'h1);
        check("single_cnt", 32'(txn_cnt), 32'h1);
        req = 4'b0000;
        tick();
        tick();
        check("single_release_gnt", 32'(gnt), 32'h0);
        check("single_release_busy", 32'(busy), 32'h0);

        // Exhaustive parity through requester 2
        apply_reset();
        for (int k = 0; k < 16; k++) begin
            v = 4'(k);
            op[11:8] = v;
            req = 4'b0100;
            wait_done();
            par = v[0] ^ v[1] ^ v[2] ^ v[3];
            check("parity_result", 32'(result), 32'(par));
            req = 4'b0000;
            wait_idle();
        end
        check("parity_cnt", 32'(txn_cnt), 32'd16);

        // Fairness with all four requesting
        apply_reset();
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        got_q = {};
        op  = 16'h5A3C;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_done();
            got_q.push_back(gnt_id);
            w = int'(gnt_id);
            req[w] = 1'b0;
            tick();
            tick();
            req[w] = 1'b1;
        end
        while (exp_q.size() > 0) begin
            e_id = exp_q.pop_front();
            if (got_q.size() > 0) check("fair_order", 32'(got_q.pop_front()), 32'(e_id));
            else check("fair_order_missing", 32'hFF, 32'(e_id));
        end
        req = 4'b0000;
        wait_idle();

        // Abort: requester 1 drops during EVAL, requester 2 pending
        apply_reset();
        op  = 16'h0070;
        req = 4'b0110;
        tick();
        check("abort_gnt", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        tick();
        check("abort_done", 32'(done), 32'h1);
        tick();
        check("abort_wait_gnt", 32'(gnt), 32'h2);
        tick();
        check("abort_exit_gnt", 32'(gnt), 32'h0);
        tick();
        check("abort_next_gnt", 32'(gnt), 32'h4);
        wait_done();
        req = 4'b0000;
        wait_idle();

        // Operand changes after grant must not affect the result
        apply_reset();
        op  = 16'h0010;
        req = 4'b0010;
        tick();
        op[7:4] = 4'b0011;
        tick();
        check("latch_done", 32'(done), 32'h1);
        check("latch_result", 32'(result), 32'h1);
        req = 4'b0000;
        wait_idle();

        // Reset in EVAL after the pointer has advanced
        apply_reset();
        req = 4'b0001;
        wait_done();
        req = 4'b0000;
        wait_idle();
        req = 4'b0001;
        tick();
        reset_n = 1'b0;
        #1;
        check("midrst_gnt", 32'(gnt), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_result", 32'(result), 32'h0);
        check("midrst_id", 32'(gnt_id), 32'h0);
        check("midrst_cnt", 32'(txn_cnt), 32'h0);
        req = 4'b0011;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("postrst_gnt", 32'(gnt), 32'h1);
        check("postrst_done", 32'(done), 32'h0);
        req = 4'b0000;
        wait_idle();

        // Random traffic, 256 transactions for counter wrap
        apply_reset();
        for (int n = 0; n < 256; n++) begin
            req = 4'($urandom_range(1, 15));
            op  = 16'($urandom);
            wait_done();
            repeat ($urandom_range(0, 2)) begin
                op = 16'($urandom);
                tick();
            end
            r = 4'($urandom_range(0, 15));
            r[gnt_id] = 1'b0;
            req = r;
            wait_idle();
        end
        check("wrap_cnt", 32'(txn_cnt), 32'h0);
        req = 4'b0000;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
